// File: rtl/instr_queue_if.sv
// Instruction queue handshake bundle between IF (producer), the queue and ID
// (consumer).
//   master : environment side. Drives IN_* and OUT_READY, and observes the
//            queue outputs.
//   slave  : queue side. Accepts IN_*, presents OUT_*, and reports
//            COUNT/ALMOST_FULL.
// Parameters:
//   INSTR_W : instruction width in bits.
//   PC_W    : PC width in bits.
//   DEPTH   : number of storage entries; sets the COUNT width.
interface instr_queue_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned DEPTH   = 8
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               IN_VALID;
  logic [INSTR_W-1:0] IN_INSTR;
  logic [PC_W-1:0]    IN_PC;
  logic               IN_READY;
  logic               OUT_VALID;
  logic [INSTR_W-1:0] OUT_INSTR;
  logic [PC_W-1:0]    OUT_PC;
  logic               OUT_READY;
  logic [CW-1:0]      COUNT;
  logic               ALMOST_FULL;

  modport master (
    output IN_VALID, IN_INSTR, IN_PC, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_INSTR, OUT_PC, COUNT, ALMOST_FULL
  );

  modport slave (
    input  IN_VALID, IN_INSTR, IN_PC, OUT_READY,
    output IN_READY, OUT_VALID, OUT_INSTR, OUT_PC, COUNT, ALMOST_FULL
  );
endinterface

// File: rtl/instr_queue.sv
// IF->ID instruction queue: a circular buffer with an optional registered
// output stage.
// Ports:
//   CLK     : single clock; all state changes on its rising edge.
//   RESET_N : asynchronous active-low reset; clears the pointers and the
//             output stage.
//   FLUSH   : synchronous discard of every queued entry and of the output
//             stage. It has priority over enqueue and dequeue.
//   q       : instr_queue_if.slave. Carries the IN_* handshake, the OUT_*
//             handshake, COUNT and ALMOST_FULL.
// Parameters:
//   INSTR_W, PC_W : instruction and PC widths.
//   DEPTH         : number of storage entries; a power of two, 2..64.
//   FWFT          : 1 = first-word fall-through, 0 = registered output stage.
//   AF_MARGIN     : ALMOST_FULL is set when COUNT >= DEPTH - AF_MARGIN.
module instr_queue #(
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FWFT      = 1,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          FLUSH,
  instr_queue_if.slave  q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          full, empty, push, pop;

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = wr_ptr_q - rd_ptr_q;

  // Readiness is taken from the registered full flag only, so a pop on the
  // same edge never opens a slot in a full queue.
  assign q.IN_READY    = !full && RESET_N;
  assign q.COUNT       = count;
  assign q.ALMOST_FULL = (count >= PW'(DEPTH - AF_MARGIN));

  assign push = q.IN_VALID && q.IN_READY && !FLUSH;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The storage array needs no reset: an entry is only visible while the
  // pointers mark it as occupied.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[wr_ptr_q[AW-1:0]] <= q.IN_INSTR;
      pc_mem[wr_ptr_q[AW-1:0]]    <= q.IN_PC;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign pop         = !empty && q.OUT_READY && !FLUSH;
    assign q.OUT_VALID = !empty;
    assign q.OUT_INSTR = empty ? '0 : instr_mem[rd_ptr_q[AW-1:0]];
    assign q.OUT_PC    = empty ? '0 : pc_mem[rd_ptr_q[AW-1:0]];
  end else begin : g_oreg
    logic               ov_q, ov_d;
    logic [INSTR_W-1:0] oi_q, oi_d;
    logic [PC_W-1:0]    op_q, op_d;

    // The output register refills from storage when it is empty or is being
    // consumed on this edge. The refill is what removes the entry from
    // storage.
    assign pop = !empty && (!ov_q || q.OUT_READY) && !FLUSH;

    always_comb begin
      ov_d = ov_q;
      oi_d = oi_q;
      op_d = op_q;
      if (FLUSH) begin
        ov_d = 1'b0;
        oi_d = '0;
        op_d = '0;
      end else if (pop) begin
        ov_d = 1'b1;
        oi_d = instr_mem[rd_ptr_q[AW-1:0]];
        op_d = pc_mem[rd_ptr_q[AW-1:0]];
      end else if (ov_q && q.OUT_READY) begin
        ov_d = 1'b0;
        oi_d = '0;
        op_d = '0;
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        ov_q <= 1'b0;
        oi_q <= '0;
        op_q <= '0;
      end else begin
        ov_q <= ov_d;
        oi_q <= oi_d;
        op_q <= op_d;
      end
    end

    assign q.OUT_VALID = ov_q;
    assign q.OUT_INSTR = oi_q;
    assign q.OUT_PC    = op_q;
  end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter INSTR_W, default 32: instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 32: PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 8: storage entries; power of two, 2..64.
REQ-004 SHALL have parameter FWFT, default 1: 1 = first-word fall-through output, 0 = registered output stage.
REQ-005 SHALL have parameter AF_MARGIN, default 2: ALMOST_FULL threshold offset, 0..DEPTH-1.
REQ-006 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port RESET_N  input  1  asynchronous active-low reset; assertion clears all state immediately.
REQ-008 SHALL have port FLUSH  input  1  synchronous flush (syscall/redirect); discards all queued and output-stage entries.
REQ-009 SHALL have port IN_VALID  input  1  upstream (IF) presents an instruction.
REQ-010 SHALL have port IN_INSTR  input  INSTR_W  instruction from IF.
REQ-011 SHALL have port IN_PC  input  PC_W  instruction PC from IF.
REQ-012 SHALL have port IN_READY  output  1  queue can accept an entry this cycle.
REQ-013 SHALL have port OUT_VALID  output  1  OUT_INSTR/OUT_PC hold a valid entry for ID.
REQ-014 SHALL have port OUT_INSTR  output  INSTR_W  instruction to ID.
REQ-015 SHALL have port OUT_PC  output  PC_W  PC to ID.
REQ-016 SHALL have port OUT_READY  input  1  ID consumes the presented entry this cycle.
REQ-017 SHALL have port COUNT  output  $clog2(DEPTH)+1  occupied storage entries (excludes FWFT=0 output register).
REQ-018 SHALL have port ALMOST_FULL  output  1  COUNT >= DEPTH-AF_MARGIN.

Function
REQ-019 Enqueue SHALL occur on a rising edge where IN_VALID && IN_READY && !FLUSH; entry written at tail, tail advances by 1 modulo DEPTH.
REQ-020 Dequeue SHALL occur on a rising edge where OUT_VALID && OUT_READY && !FLUSH; head entry retired, next entry presented.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits; full = low bits equal and MSBs differ; empty = pointers equal; wrap-around SHALL be seamless.
REQ-022 IN_READY SHALL be combinational = !full && RESET_N; a simultaneous dequeue SHALL NOT make a full queue ready (no pass-through).
REQ-023 Simultaneous enqueue and dequeue when neither full nor empty SHALL leave COUNT unchanged.
REQ-024 FWFT=1: OUT_VALID = !empty; OUT_INSTR/OUT_PC driven from head entry; entry enqueued at edge N visible in the cycle after edge N.
REQ-025 FWFT=0: output register loads head entry when it is empty or being consumed and storage is non-empty; entry enqueued at edge N presented after edge N+1; the load removes it from storage.
REQ-026 OUT_INSTR/OUT_PC SHALL hold stable while OUT_VALID && !OUT_READY.
REQ-027 When OUT_VALID=0, OUT_INSTR/OUT_PC SHALL be 0.
REQ-028 FLUSH SHALL take priority over enqueue and dequeue: at that edge pointers reset to 0, all entries invalidated, output register cleared; following cycle OUT_VALID=0, COUNT=0, IN_READY=1.
REQ-029 IN_VALID asserted with FLUSH SHALL be dropped, not queued.
REQ-030 COUNT and ALMOST_FULL SHALL be registered-state derived, updated the cycle after the causing edge.

Reset
REQ-031 While RESET_N=0: OUT_VALID=0, OUT_INSTR=0, OUT_PC=0, COUNT=0, ALMOST_FULL=0, IN_READY=0, pointers 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries with no output glitch to OUT_VALID=1.
REQ-033 First enqueue SHALL be possible on the first rising edge after RESET_N deasserts.

Verification
REQ-034 DEPTH=8, FWFT=1, OUT_READY=0: enqueue PC 0x00..0x1C (8 entries) -> IN_READY=0 after 8th, COUNT=8, ALMOST_FULL=1 from COUNT=6; 9th IN_VALID not accepted.
REQ-035 Full queue, IN_VALID=1 and OUT_READY=1 same cycle -> one dequeue, no enqueue; COUNT 8->7; next cycle enqueue accepted.
REQ-036 20 streaming entries, IN_VALID=1, OUT_READY=1 constantly -> in-order PCs 0x00..0x4C, wraps twice, COUNT stays 1 (FWFT=1).
REQ-037 FWFT=0: single enqueue at edge N -> OUT_VALID rises after edge N+1, COUNT returns to 0 after N+1.
REQ-038 5 entries queued, FLUSH=1 with IN_VALID=1 (PC 0x100) -> next cycle OUT_VALID=0, COUNT=0; PC 0x100 never emerges.
REQ-039 RESET_N pulsed low asynchronously between edges with 3 entries queued -> outputs zero immediately, queue empty after release.
